// File: rtl/enable_cond_pkg.sv
// Shared types for the enable conditioner: debounce FSM state encoding
// and its reset state. Optional build macro: ENABLE_COND_TOGGLE_EN.
package enable_cond_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    CHK_HIGH = 2'b01,
    HIGH     = 2'b11,
    CHK_LOW  = 2'b10
  } state_t;

  localparam state_t RESET_STATE = LOW;

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain that brings an asynchronous level into the clock domain.
// No logic sits between stages; the last stage is the synchronized output.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  // shift the raw level through the chain, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) stage <= '0;
    else        stage <= {stage[STAGES-2:0], d};
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/enable_conditioner.sv
// Debounced enable generator: synchronizer, debounce counter and a 4-state
// FSM producing a clean level E plus one-cycle E_RISE / E_FALL pulses.
// Build option ENABLE_COND_TOGGLE_EN: each completed press inverts E and
// completed releases are ignored; FSM and latency are unchanged.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOW      | debounced level 0, counter idle at 0
// CHK_HIGH | sw_s went high, counting consecutive high samples
// HIGH     | debounced level 1, counter idle at 0
// CHK_LOW  | sw_s went low, counting consecutive low samples
module enable_conditioner
  import enable_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic SW,
  output logic E,
  output logic E_RISE,
  output logic E_FALL
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sw_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_done, release_done;
  logic             e_nxt, rise_nxt, fall_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (SW),
    .q     (sw_s)
  );

  // state, counter and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= RESET_STATE;
      cnt    <= '0;
      E      <= 1'b0;
      E_RISE <= 1'b0;
      E_FALL <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      E      <= e_nxt;
      E_RISE <= rise_nxt;
      E_FALL <= fall_nxt;
    end
  end

  // debounce next-state: the counter only runs in the two check states
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    press_done   = 1'b0;
    release_done = 1'b0;
    case (state)
      LOW: begin
        if (sw_s) begin
          state_nxt = CHK_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HIGH: begin
        if (!sw_s) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = HIGH;
          cnt_nxt    = '0;
          press_done = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sw_s) begin
          state_nxt = CHK_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LOW: begin
        if (sw_s) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = LOW;
          cnt_nxt      = '0;
          release_done = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RESET_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // E and edge pulses; pulses always reflect the actual change of E
  always_comb begin
    e_nxt    = E;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
`ifdef ENABLE_COND_TOGGLE_EN
    if (press_done) begin
      e_nxt    = ~E;
      rise_nxt = ~E;
      fall_nxt = E;
    end else if (release_done) begin
      e_nxt = E;  // release completion leaves the toggled level alone
    end
`else
    if (press_done) begin
      e_nxt    = 1'b1;
      rise_nxt = 1'b1;
    end else if (release_done) begin
      e_nxt    = 1'b0;
      fall_nxt = 1'b1;
    end
`endif
  end

endmodule
